// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer and dat_mem arbiter around the single-cycle core.
// While idle or done, the host owns dat_mem and the core is held in reset.
// On start the core runs, and its execution cycles are counted. When the core
// reports done, or the watchdog expires, there is one drain cycle, and then
// dat_mem returns to the host.
// Optional feature: define RUN_WDOG_EN to enable the MAX_CYC run watchdog.
module run_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CW      = 16,
  parameter int MAX_CYC = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_gnt,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  input  logic          core_done,
  output logic          core_rst,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  state_t   state, nxt;
  mem_req_t host_req, core_req, mem_req;
  logic     launch;
  logic     wdog_hit;

  assign launch = (state == IDLE || state == DONE) && start;

`ifdef RUN_WDOG_EN
  localparam logic [CW-1:0] WDOG_LIM = CW'(MAX_CYC - 1);

  // The watchdog only fires when the core did not finish in that same cycle.
  assign wdog_hit = (state == RUN) && !core_done && (cycle_cnt == WDOG_LIM);

  // The timeout flag is sticky until the next launch.
  always_ff @(posedge clk) begin
    if (!reset)        timeout <= 1'b0;
    else if (launch)   timeout <= 1'b0;
    else if (wdog_hit) timeout <= 1'b1;
  end
`else
  wire unused_cfg = (MAX_CYC == 0);
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic: a run ends on core_done or on a watchdog expiry.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = RUN;
      RUN:        if (core_done || wdog_hit) nxt = DRAIN;
      DRAIN:      nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state, so they change in
  // step with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      core_rst <= 1'b1;
      host_gnt <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      core_rst <= (nxt != RUN);
      host_gnt <= (nxt == IDLE) || (nxt == DONE);
      busy     <= (nxt == RUN) || (nxt == DRAIN);
      done     <= (nxt == DONE);
    end
  end

  // The cycle counter clears on launch, then counts RUN cycles and
  // saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!reset)
      cycle_cnt <= '0;
    else if (launch)
      cycle_cnt <= '0;
    else if (state == RUN && cycle_cnt != {CW{1'b1}})
      cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign host_req = '{we: host_we, addr: host_addr, wdata: host_wdata};
  assign core_req = '{we: core_we, addr: core_addr, wdata: core_wdata};

  // Ownership mux. In DRAIN the core still drives address and data, but
  // no write happens; a host write during RUN is simply dropped.
  always_comb begin
    mem_req    = core_req;
    mem_req.we = 1'b0;
    if (host_gnt)           mem_req = host_req;
    else if (state == RUN)  mem_req = core_req;
  end

  assign mem_we     = mem_req.we;
  assign mem_addr   = mem_req.addr;
  assign mem_wdata  = mem_req.wdata;
  assign host_rdata = mem_rdata;
  assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl. It uses a behavioural dat_mem and a reference
// copy of the expected memory contents, and a queue of expected values that
// are pushed at drive time and popped at sample time.
module tb_run_ctrl;
  localparam int AW = 8, DW = 8, CW = 6, MAX_CYC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_gnt;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_done;
  logic          core_rst;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;

  run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_gnt(host_gnt),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_done(core_done), .core_rst(core_rst),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  logic [DW-1:0] ref_mem [0:255];
  logic [31:0]   exp_q [$];
  int            tests = 0;
  int            fails = 0;

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc();
    host_we = 1'b1; host_addr = a; host_wdata = d; ref_mem[a] = d;
    sb_push(1); sb_push(32'(a));
    smp(); chk("host_wr mem_we", 32'(mem_we)); chk("host_wr mem_addr", 32'(mem_addr));
    cyc();
    host_we = 1'b0;
    sb_push(0);
    smp(); chk("host_wr mem_we pulse", 32'(mem_we));
  endtask

  task automatic host_rd(input logic [AW-1:0] a);
    cyc();
    host_addr = a;
    sb_push(32'(ref_mem[a]));
    smp(); chk("host_rd data", 32'(host_rdata));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    core_we = 1'b0; core_addr = '0; core_wdata = '0; core_done = 1'b0;
    repeat (2) cyc();
    sb_push(1); sb_push(0); sb_push(0); sb_push(0); sb_push(0); sb_push(1);
    smp();
    chk("rst core_rst", 32'(core_rst)); chk("rst busy", 32'(busy));
    chk("rst done", 32'(done)); chk("rst timeout", 32'(timeout));
    chk("rst cycle_cnt", 32'(cycle_cnt)); chk("rst host_gnt", 32'(host_gnt));
    cyc(); reset = 1'b1;

    // Host preload and readback.
    host_wr(8'h10, 8'hA5);
    host_rd(8'h10);
    host_wr(8'h20, 8'h11);
    host_wr(8'h30, 8'h00);
    host_wr(8'h40, 8'h00);

    // Run 1: core_done on the 37th RUN cycle.
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    sb_push(1); sb_push(0); sb_push(0); sb_push(0);
    smp();
    chk("run busy", 32'(busy)); chk("run core_rst", 32'(core_rst));
    chk("run host_gnt", 32'(host_gnt)); chk("run cycle_cnt0", 32'(cycle_cnt));
    for (int c = 2; c <= 37; c++) begin
      cyc();
      if (c == 2) begin
        host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h55;
        sb_push(0); smp(); chk("run host_we dropped", 32'(mem_we));
      end else if (c == 3) begin
        core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h99; ref_mem[8'h40] = 8'h99;
        sb_push(1); sb_push(32'h40);
        smp(); chk("run core mem_we", 32'(mem_we)); chk("run core mem_addr", 32'(mem_addr));
      end else if (c == 4) begin
        core_we = 1'b0; host_we = 1'b0; start = 1'b1;
      end else if (c == 5) begin
        start = 1'b0;
        sb_push(4); smp(); chk("run start ignored cnt", 32'(cycle_cnt));
      end else if (c == 37) begin
        core_we = 1'b1; core_addr = 8'h30; core_wdata = 8'h7E; core_done = 1'b1;
        ref_mem[8'h30] = 8'h7E;
        sb_push(1); smp(); chk("last write mem_we", 32'(mem_we));
      end
    end
    cyc(); core_done = 1'b0; core_addr = 8'h60;
    sb_push(1); sb_push(1); sb_push(0); sb_push(0); sb_push(37);
    smp();
    chk("drain busy", 32'(busy)); chk("drain core_rst", 32'(core_rst));
    chk("drain mem_we", 32'(mem_we)); chk("drain done", 32'(done));
    chk("drain cycle_cnt", 32'(cycle_cnt));
    cyc(); core_we = 1'b0;
    sb_push(1); sb_push(0); sb_push(0); sb_push(1); sb_push(37);
    smp();
    chk("done done", 32'(done)); chk("done busy", 32'(busy));
    chk("done timeout", 32'(timeout)); chk("done host_gnt", 32'(host_gnt));
    chk("done cycle_cnt", 32'(cycle_cnt));
    host_rd(8'h30);
    host_rd(8'h20);
    host_rd(8'h40);

    // Run 2: no core_done.
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
`ifdef RUN_WDOG_EN
    for (int c = 2; c <= 16; c++) cyc();
    cyc();
    sb_push(1); sb_push(16); sb_push(1); sb_push(0);
    smp();
    chk("wdog timeout", 32'(timeout)); chk("wdog cycle_cnt", 32'(cycle_cnt));
    chk("wdog drain busy", 32'(busy)); chk("wdog drain done", 32'(done));
    cyc();
    sb_push(1); sb_push(1);
    smp(); chk("wdog done", 32'(done)); chk("wdog timeout sticky", 32'(timeout));
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    sb_push(0); sb_push(0);
    smp(); chk("restart timeout", 32'(timeout)); chk("restart cycle_cnt", 32'(cycle_cnt));
    for (int c = 2; c <= 16; c++) begin
      cyc();
      if (c == 16) core_done = 1'b1;
    end
    cyc(); core_done = 1'b0;
    sb_push(0); sb_push(16);
    smp(); chk("coincide timeout", 32'(timeout)); chk("coincide cycle_cnt", 32'(cycle_cnt));
    cyc();
    sb_push(1); smp(); chk("coincide done", 32'(done));
`else
    for (int c = 2; c <= 70; c++) cyc();
    sb_push(1); sb_push(63); sb_push(0);
    smp();
    chk("long run busy", 32'(busy)); chk("long run saturate", 32'(cycle_cnt));
    chk("long run timeout", 32'(timeout));
    cyc(); core_done = 1'b1;
    cyc(); core_done = 1'b0;
    cyc();
    sb_push(1); sb_push(63);
    smp(); chk("long run done", 32'(done)); chk("long run cnt held", 32'(cycle_cnt));
`endif

    // Run 3: reset asserted mid-run aborts it; the core write still lands.
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    repeat (5) cyc();
    reset = 1'b0; core_we = 1'b1; core_addr = 8'h50; core_wdata = 8'h3C;
    ref_mem[8'h50] = 8'h3C;
    cyc(); core_we = 1'b0;
    sb_push(1); sb_push(0); sb_push(0); sb_push(0); sb_push(1);
    smp();
    chk("midrst core_rst", 32'(core_rst)); chk("midrst done", 32'(done));
    chk("midrst busy", 32'(busy)); chk("midrst cycle_cnt", 32'(cycle_cnt));
    chk("midrst host_gnt", 32'(host_gnt));
    cyc(); reset = 1'b1;
    host_rd(8'h50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
